// File: rtl/sprite_queue.sv
// Show-ahead FIFO of {id, x, y, scale} sprite draw commands feeding the sprite distributor.
// The head entry is held in its own register so consumers see it with no read latency.
module sprite_queue #(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [7:0]       enq_sprite_id,
   input  logic [15:0]      enq_sprite_x,
   input  logic [15:0]      enq_sprite_y,
   input  logic [7:0]       enq_sprite_scale,
   input  logic             sprite_queue_dequeue,
   output logic             sprite_queue_is_empty,
   output logic [7:0]       sprite_queue_sprite_id,
   output logic [15:0]      sprite_queue_sprite_x,
   output logic [15:0]      sprite_queue_sprite_y,
   output logic [7:0]       sprite_queue_sprite_scale,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [47:0]      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             full;
   logic             empty;
   logic [47:0]      head;
   logic [47:0]      head_nxt;
   logic [47:0]      enq_data;
   logic             do_enq;
   logic             do_deq;

   assign enq_data   = {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale};
   assign enq_ready  = !full;
   assign do_enq     = enq_valid && !full && !flush;
   assign do_deq     = sprite_queue_dequeue && !empty && !flush;
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);

   always_comb begin
      cnt_nxt = cnt;
      if (do_enq && !do_deq)
         cnt_nxt = cnt + ONE_C;
      else if (do_deq && !do_enq)
         cnt_nxt = cnt - ONE_C;
   end

   // Head follows the pop: next stored entry, or the incoming one when it
   // would otherwise be the only entry left.
   always_comb begin
      head_nxt = head;
      if (do_deq) begin
         if (cnt == ONE_C) begin
            if (do_enq)
               head_nxt = enq_data;
         end else begin
            head_nxt = mem[rd_ptr_inc];
         end
      end else if (do_enq && empty) begin
         head_nxt = enq_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         head      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         head   <= '0;
      end else begin
         if (do_enq)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_deq)
            rd_ptr <= rd_ptr_inc;
         cnt   <= cnt_nxt;
         full  <= (cnt_nxt == DEPTH_C);
         empty <= (cnt_nxt == '0);
         head  <= head_nxt;
         // A refused push alongside a pop is a normal retry, not an overflow.
         if (enq_valid && full && !sprite_queue_dequeue)
            overflow <= 1'b1;
         if (sprite_queue_dequeue && empty)
            underflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && do_enq)
         mem[wr_ptr] <= enq_data;
   end

   assign sprite_queue_is_empty     = empty;
   assign count                     = cnt;
   assign sprite_queue_sprite_id    = head[47:40];
   assign sprite_queue_sprite_x     = head[39:24];
   assign sprite_queue_sprite_y     = head[23:8];
   assign sprite_queue_sprite_scale = head[7:0];

endmodule

// File: tb/tb_sprite_queue.sv
// Self-checking bench for sprite_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_sprite_queue;

   localparam int DEPTH = 64;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clock;
   logic             reset;
   logic             flush;
   logic             enq_valid;
   logic             enq_ready;
   logic [7:0]       enq_sprite_id;
   logic [15:0]      enq_sprite_x;
   logic [15:0]      enq_sprite_y;
   logic [7:0]       enq_sprite_scale;
   logic             sprite_queue_dequeue;
   logic             sprite_queue_is_empty;
   logic [7:0]       sprite_queue_sprite_id;
   logic [15:0]      sprite_queue_sprite_x;
   logic [15:0]      sprite_queue_sprite_y;
   logic [7:0]       sprite_queue_sprite_scale;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   sprite_queue #(.DEPTH(DEPTH)) dut (
      .clock                     (clock),
      .reset                     (reset),
      .flush                     (flush),
      .enq_valid                 (enq_valid),
      .enq_ready                 (enq_ready),
      .enq_sprite_id             (enq_sprite_id),
      .enq_sprite_x              (enq_sprite_x),
      .enq_sprite_y              (enq_sprite_y),
      .enq_sprite_scale          (enq_sprite_scale),
      .sprite_queue_dequeue      (sprite_queue_dequeue),
      .sprite_queue_is_empty     (sprite_queue_is_empty),
      .sprite_queue_sprite_id    (sprite_queue_sprite_id),
      .sprite_queue_sprite_x     (sprite_queue_sprite_x),
      .sprite_queue_sprite_y     (sprite_queue_sprite_y),
      .sprite_queue_sprite_scale (sprite_queue_sprite_scale),
      .count                     (count),
      .overflow                  (overflow),
      .underflow                 (underflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          n_vec;
   int          n_err;
   logic [47:0] mq[$];
   logic        m_ovf;
   logic        m_unf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [47:0] mk(input int id, input int x, input int y, input int s);
      return {8'(id), 16'(x), 16'(y), 8'(s)};
   endfunction

   function automatic logic [47:0] rnd48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   task automatic check_state();
      chk("count", 64'(count), 64'(mq.size()));
      chk("is_empty", 64'(sprite_queue_is_empty), 64'(mq.size() == 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
      if (mq.size() > 0)
         chk("head", 64'({sprite_queue_sprite_id, sprite_queue_sprite_x,
                          sprite_queue_sprite_y, sprite_queue_sprite_scale}), 64'(mq[0]));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_state();
      chk("rst_ready", 64'(enq_ready), 64'(1));
      chk("rst_head", 64'({sprite_queue_sprite_id, sprite_queue_sprite_x,
                           sprite_queue_sprite_y, sprite_queue_sprite_scale}), 64'(0));
   endtask

   // One clock: drive inputs, check ready before the edge, advance the model, check after.
   task automatic step(input logic ev, input logic ed, input logic fl, input logic [47:0] d);
      int sz;
      enq_valid            = ev;
      sprite_queue_dequeue = ed;
      flush                = fl;
      {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale} = d;
      sz = mq.size();
      chk("enq_ready", 64'(enq_ready), 64'(sz < DEPTH));
      @(posedge clock);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (ev && sz == DEPTH && !ed) m_ovf = 1'b1;
         if (ed && sz == 0) m_unf = 1'b1;
         if (ed && sz > 0) void'(mq.pop_front());
         if (ev && sz < DEPTH) mq.push_back(d);
      end
      enq_valid            = 1'b0;
      sprite_queue_dequeue = 1'b0;
      flush                = 1'b0;
      check_state();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      flush = 1'b0;
      enq_valid = 1'b0;
      sprite_queue_dequeue = 1'b0;
      {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale} = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #1;
      do_reset();

      // single enqueue is visible right after the edge
      step(1, 0, 0, mk(3, 100, 50, 8));
      chk("t1_id", 64'(sprite_queue_sprite_id), 64'(3));
      chk("t1_x", 64'(sprite_queue_sprite_x), 64'(100));
      chk("t1_count", 64'(count), 64'(1));

      // five in, five back-to-back pops
      do_reset();
      for (int i = 1; i <= 5; i++) step(1, 0, 0, mk(i, i * 10, i * 20, i));
      for (int i = 1; i <= 5; i++) begin
         chk("t2_head_id", 64'(sprite_queue_sprite_id), 64'(i));
         step(0, 1, 0, '0);
      end
      chk("t2_empty", 64'(sprite_queue_is_empty), 64'(1));
      chk("t2_unf", 64'(underflow), 64'(0));

      // fill, overflow, then pop+push at full
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, mk(i + 1, i, i, 0));
      chk("t3_ready", 64'(enq_ready), 64'(0));
      step(1, 0, 0, mk(200, 0, 0, 0));
      chk("t3_ovf", 64'(overflow), 64'(1));
      chk("t3_cnt64", 64'(count), 64'(DEPTH));
      step(1, 1, 0, mk(201, 0, 0, 0));
      chk("t3_cnt63", 64'(count), 64'(DEPTH - 1));
      chk("t3_head", 64'(sprite_queue_sprite_id), 64'(2));

      // simultaneous push/pop with a single entry
      do_reset();
      step(1, 0, 0, mk(7, 1, 2, 3));
      step(1, 1, 0, mk(9, 4, 5, 6));
      chk("t4_id", 64'(sprite_queue_sprite_id), 64'(9));
      chk("t4_cnt", 64'(count), 64'(1));

      // pointer wrap with bursts of 10
      do_reset();
      for (int b = 0; b < 10; b++) begin
         for (int i = 0; i < 10; i++) step(1, 0, 0, rnd48());
         for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
      end

      // flush with same-cycle enqueue, then underflow, then reset
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 0, rnd48());
      step(1, 0, 1, mk(42, 0, 0, 0));
      chk("t6_cnt", 64'(count), 64'(0));
      chk("t6_ovf", 64'(overflow), 64'(0));
      step(0, 1, 0, '0);
      chk("t6_unf", 64'(underflow), 64'(1));
      do_reset();
      chk("t6_rst_unf", 64'(underflow), 64'(0));

      // randomized traffic with varying push/pop bias to reach both full and empty
      for (int p = 0; p < 6; p++) begin
         int pe;
         int pd;
         pe = (p % 2 == 0) ? 80 : 25;
         pd = (p % 2 == 0) ? 30 : 75;
         for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) < pe, $urandom_range(99) < pd,
                 $urandom_range(199) == 0, rnd48());
         end
      end
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
